// File: rtl/vlc_bit_packer_pkg.sv
// Shared definitions for the VLC bit packer: widths, FSM encoding, output payload.
package vlc_bit_packer_pkg;

  localparam int unsigned OUT_W   = 32;
  localparam int unsigned ACC_W   = 64;
  localparam int unsigned BCNT_W  = 7;
  localparam int unsigned BYTES_W = 3;
  localparam int unsigned SUM_W   = OUT_W + 1;

  // RBSP stop bit that opens the slice trailing bits
  localparam logic RBSP_STOP_BIT = 1'b1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    TRAIL = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [OUT_W-1:0]   data;
    logic [BYTES_W-1:0] bytes;
    logic               last;
  } out_word_t;

  // Bit count after the stop bit at pos plus zero padding to the next byte boundary
  function automatic logic [BCNT_W-1:0] align_after_stop(input logic [BCNT_W-1:0] pos);
    return (pos + BCNT_W'(8)) & ~BCNT_W'(7);
  endfunction

endpackage

// File: rtl/vlc_bit_packer_if.sv
// Code-beat input and packed-word output handshakes of the bit packer.
// master = upstream encoder plus downstream writer, slave = packer.
interface vlc_bit_packer_if #(
  parameter int unsigned CODE_W = 16,
  parameter int unsigned LEN_W  = 5
);
  import vlc_bit_packer_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [CODE_W-1:0]   in_code;
  logic [LEN_W-1:0]    in_len;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_data;
  logic [BYTES_W-1:0]  out_bytes;
  logic                out_last;

  modport master (
    output in_valid, in_code, in_len, out_ready,
    input  in_ready, out_valid, out_data, out_bytes, out_last
  );

  modport slave (
    input  in_valid, in_code, in_len, out_ready,
    output in_ready, out_valid, out_data, out_bytes, out_last
  );

endinterface

// File: rtl/vlc_bit_packer_out_reg.sv
// Single-entry output register for packed words; holds the word while stalled.
module vlc_out_reg
  import vlc_bit_packer_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load_i,
  input  out_word_t word_i,
  input  logic      out_ready_i,
  output logic      out_valid_o,
  output out_word_t word_o,
  output logic      free_c
);

  logic      valid_q;
  out_word_t word_q;

  // Entry may be reloaded when empty or being accepted this cycle
  assign free_c      = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign word_o      = word_q;

  // Load a new word, or retire the current one on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      word_q  <= word_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/vlc_bit_packer.sv
// Packs right-aligned variable-length codes MSB-first into 32-bit words and
// closes slices with RBSP trailing bits and byte alignment.
// Optional: define VLC_PACKER_STAT_EN to add the saturating bit_total counter.
module vlc_bit_packer
  import vlc_bit_packer_pkg::*;
#(
  parameter int unsigned CODE_W = 16,
  parameter int unsigned LEN_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  vlc_bit_packer_if.slave  bus,
  input  logic             flush_req,
  output logic             flush_done,
  output logic             len_err
`ifdef VLC_PACKER_STAT_EN
  ,
  output logic [OUT_W-1:0] bit_total
`endif
);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_s, code_masked;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d, bcnt_s, added;
  logic              last_sent_q, last_sent_d;
  logic              len_err_q, len_err_d;
  logic              in_ready_q, flush_done_q;
  logic              len_over, accept, load, out_free_c;
  logic [LEN_W-1:0]  len_eff;
  out_word_t         word, out_word;

  assign len_over    = 32'(bus.in_len) > CODE_W;
  assign len_eff     = len_over ? LEN_W'(CODE_W) : bus.in_len;
  assign code_masked = ACC_W'(bus.in_code) & ((ACC_W'(1) << len_eff) - ACC_W'(1));
  assign accept      = bus.in_valid && in_ready_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = out_word.data;
  assign bus.out_bytes = out_word.bytes;
  assign bus.out_last  = out_word.last;
  assign flush_done    = flush_done_q;
  assign len_err       = len_err_q;

  vlc_out_reg u_out_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .word_i      (word),
    .out_ready_i (bus.out_ready),
    .out_valid_o (bus.out_valid),
    .word_o      (out_word),
    .free_c      (out_free_c)
  );

  // Next-state: word emit first, then append beat or trailing bits at post-shift position
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    bcnt_d      = bcnt_q;
    last_sent_d = last_sent_q;
    len_err_d   = len_err_q;
    acc_s       = acc_q;
    bcnt_s      = bcnt_q;
    added       = '0;
    load        = 1'b0;
    word        = '0;
    unique case (state_q)
      RUN, TRAIL: begin
        if (bcnt_q >= BCNT_W'(OUT_W) && out_free_c) begin
          load       = 1'b1;
          word.data  = acc_q[ACC_W-1 -: OUT_W];
          word.bytes = BYTES_W'(4);
          acc_s      = acc_q << OUT_W;
          bcnt_s     = bcnt_q - BCNT_W'(OUT_W);
        end
        acc_d  = acc_s;
        bcnt_d = bcnt_s;
        if (state_q == RUN) begin
          if (accept) begin
            acc_d  = acc_s | (code_masked << (BCNT_W'(ACC_W) - bcnt_s - BCNT_W'(len_eff)));
            bcnt_d = bcnt_s + BCNT_W'(len_eff);
            added  = BCNT_W'(len_eff);
            if (len_over) len_err_d = 1'b1;
          end
          if (flush_req) state_d = TRAIL;
        end else begin
          acc_d       = acc_s | (ACC_W'(RBSP_STOP_BIT) << (BCNT_W'(ACC_W - 1) - bcnt_s));
          bcnt_d      = align_after_stop(bcnt_s);
          added       = bcnt_d - bcnt_s;
          last_sent_d = 1'b0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (last_sent_q || bcnt_q == '0) begin
          if (out_free_c) state_d = DONE;
        end else if (out_free_c) begin
          load        = 1'b1;
          word.data   = acc_q[ACC_W-1 -: OUT_W];
          last_sent_d = 1'b1;
          if (bcnt_q >= BCNT_W'(OUT_W)) begin
            word.bytes = BYTES_W'(4);
            word.last  = (bcnt_q == BCNT_W'(OUT_W));
            last_sent_d = word.last;
            acc_d      = acc_q << OUT_W;
            bcnt_d     = bcnt_q - BCNT_W'(OUT_W);
          end else begin
            word.bytes = BYTES_W'(bcnt_q >> 3);
            word.last  = 1'b1;
            acc_d      = '0;
            bcnt_d     = '0;
          end
        end
      end
      DONE: begin
        acc_d       = '0;
        bcnt_d      = '0;
        last_sent_d = 1'b0;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State, accumulator and registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      acc_q        <= '0;
      bcnt_q       <= '0;
      last_sent_q  <= 1'b0;
      len_err_q    <= 1'b0;
      in_ready_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      bcnt_q       <= bcnt_d;
      last_sent_q  <= last_sent_d;
      len_err_q    <= len_err_d;
      in_ready_q   <= (state_d == RUN) && (bcnt_d <= BCNT_W'(OUT_W));
      flush_done_q <= (state_d == DONE);
    end
  end

`ifdef VLC_PACKER_STAT_EN
  logic [OUT_W-1:0] bit_total_q, bit_total_d;
  logic [SUM_W-1:0] total_sum;

  // Saturating per-slice bit count, cleared the cycle after flush_done
  always_comb begin
    total_sum   = SUM_W'(bit_total_q) + SUM_W'(added);
    bit_total_d = total_sum[OUT_W] ? '1 : total_sum[OUT_W-1:0];
    if (state_q == DONE) bit_total_d = '0;
  end

  // Bit total register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bit_total_q <= '0;
    else        bit_total_q <= bit_total_d;
  end

  assign bit_total = bit_total_q;
`else
  logic unused_added;
  assign unused_added = ^added;
`endif

endmodule

// File: tb/tb_vlc_bit_packer.sv
// Directed bench for vlc_bit_packer; bit_total checks compiled in with VLC_PACKER_STAT_EN.
module tb_vlc_bit_packer;
  import vlc_bit_packer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_req = 1'b0;
  logic flush_done, len_err;
`ifdef VLC_PACKER_STAT_EN
  logic [31:0] bit_total;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;
  int fd_cnt  = 0;
  out_word_t got_q[$];

  vlc_bit_packer_if #(.CODE_W(16), .LEN_W(5)) bus ();

  vlc_bit_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .len_err    (len_err)
`ifdef VLC_PACKER_STAT_EN
    ,
    .bit_total  (bit_total)
`endif
  );

  always #5 clk = ~clk;

  // Record accepted words and flush_done pulses
  always @(posedge clk) begin
    out_word_t w;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      w.data  = bus.out_data;
      w.bytes = bus.out_bytes;
      w.last  = bus.out_last;
      got_q.push_back(w);
    end
    if (rst_n && flush_done) fd_cnt++;
  end

  task automatic send_beat(input logic [15:0] c, input logic [4:0] l);
    bit ok;
    int n;
    bus.in_valid = 1'b1;
    bus.in_code  = c;
    bus.in_len   = l;
    n = 0;
    do begin
      ok = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 500);
    bus.in_valid = 1'b0;
    if (!ok) begin
      vec_cnt++; err_cnt++;
      $display("FAIL beat_accept: in_ready never seen for code %h len %0d", c, l);
    end
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
  endtask

  task automatic wait_words(input int n, output bit ok);
    int k = 0;
    while (got_q.size() < n && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic wait_flush_done(output bit ok);
    int k = 0;
    while (!flush_done && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    ok = flush_done;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_code = '0; bus.in_len = '0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_bytes, bus.out_last, flush_done, len_err} !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h bytes=%0d last=%b fd=%b lerr=%b want all 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_bytes, bus.out_last, flush_done, len_err);
    end
`ifdef VLC_PACKER_STAT_EN
    vec_cnt++;
    if (bit_total !== 32'd0) begin err_cnt++; $display("FAIL reset_bit_total: got %h want 0", bit_total); end
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    vec_cnt++;
    if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_word_pack();
    got_q.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(16'h1, 5'd4);
    vec_cnt++;
    if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL pack_latency_early: out_valid got %b want 0", bus.out_valid); end
    @(posedge clk); #1;
    vec_cnt++;
    if ({bus.out_valid, bus.out_data, bus.out_bytes, bus.out_last} !== {1'b1, 32'h11111111, 3'd4, 1'b0}) begin
      err_cnt++;
      $display("FAIL pack_word: got vld=%b data=%h bytes=%0d last=%b want 1 11111111 4 0",
               bus.out_valid, bus.out_data, bus.out_bytes, bus.out_last);
    end
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if (got_q.size() !== 1) begin err_cnt++; $display("FAIL pack_count: got %0d words want 1", got_q.size()); end
    vec_cnt++;
    if (len_err !== 1'b0) begin err_cnt++; $display("FAIL len_err_clean: got %b want 0", len_err); end
  endtask

  task automatic test_flush_partial();
    bit ok;
    out_word_t exp;
    got_q.delete(); fd_cnt = 0;
    bus.out_ready = 1'b1;
    send_beat(16'h01FF, 5'd9);
    send_beat(16'h0007, 5'd3);
    send_beat(16'h0000, 5'd0);
    send_beat(16'h0005, 5'd4);
    pulse_flush();
    wait_flush_done(ok);
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL flush_partial_done: flush_done got 0 want 1 within bound"); end
`ifdef VLC_PACKER_STAT_EN
    vec_cnt++;
    if (bit_total !== 32'd24) begin err_cnt++; $display("FAIL bit_total_slice: got %0d want 24", bit_total); end
`endif
    @(posedge clk); #1;
    vec_cnt++;
    if (flush_done !== 1'b0) begin err_cnt++; $display("FAIL flush_done_pulse: got %b want 0", flush_done); end
`ifdef VLC_PACKER_STAT_EN
    vec_cnt++;
    if (bit_total !== 32'd0) begin err_cnt++; $display("FAIL bit_total_clear: got %0d want 0", bit_total); end
`endif
    repeat (3) @(posedge clk);
    #1;
    exp = '{data: 32'hFFF58000, bytes: 3'd3, last: 1'b1};
    vec_cnt++;
    if (got_q.size() !== 1 || got_q[0] !== exp) begin
      err_cnt++;
      $display("FAIL flush_partial_word: got n=%0d w=%h want n=1 w=%h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : out_word_t'('0), exp);
    end
    vec_cnt++;
    if (fd_cnt !== 1) begin err_cnt++; $display("FAIL flush_partial_fdcnt: got %0d want 1", fd_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok;
    got_q.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(16'hFFFF, 5'd16);
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if ({bus.in_ready, bus.out_valid} !== 2'b01) begin
      err_cnt++;
      $display("FAIL bp_stall: got rdy=%b vld=%b want rdy=0 vld=1", bus.in_ready, bus.out_valid);
    end
    vec_cnt++;
    if (bus.out_data !== 32'hFFFFFFFF) begin err_cnt++; $display("FAIL bp_hold: got %h want ffffffff", bus.out_data); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(16'hFFFF, 5'd16);
    wait_words(4, ok);
    repeat (5) @(posedge clk);
    #1;
    vec_cnt++;
    if (!ok || got_q.size() !== 4) begin err_cnt++; $display("FAIL bp_count: got %0d words want 4", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      vec_cnt++;
      if (got_q[i] !== out_word_t'{data: 32'hFFFFFFFF, bytes: 3'd4, last: 1'b0}) begin
        err_cnt++;
        $display("FAIL bp_word%0d: got %h want ffffffff/4/0", i, got_q[i]);
      end
    end
  endtask

  task automatic test_exact_word_flush();
    bit ok;
    got_q.delete(); fd_cnt = 0;
    bus.out_ready = 1'b1;
    send_beat(16'hABCD, 5'd16);
    send_beat(16'h1234, 5'd16);
    pulse_flush();
    wait_flush_done(ok);
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL exact_flush_done: flush_done got 0 want 1 within bound"); end
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if (got_q.size() !== 2) begin
      err_cnt++;
      $display("FAIL exact_count: got %0d words want 2", got_q.size());
    end else begin
      vec_cnt++;
      if (got_q[0] !== out_word_t'{data: 32'hABCD1234, bytes: 3'd4, last: 1'b0}) begin
        err_cnt++; $display("FAIL exact_full_word: got %h want abcd1234/4/0", got_q[0]);
      end
      vec_cnt++;
      if (got_q[1] !== out_word_t'{data: 32'h80000000, bytes: 3'd1, last: 1'b1}) begin
        err_cnt++; $display("FAIL exact_stop_word: got %h want 80000000/1/1", got_q[1]);
      end
    end
  endtask

  task automatic test_len_err_and_reset();
    bit ok;
    got_q.delete();
    bus.out_ready = 1'b1;
    send_beat(16'hABCD, 5'd20);
    vec_cnt++;
    if (len_err !== 1'b1) begin err_cnt++; $display("FAIL len_err_set: got %b want 1", len_err); end
    send_beat(16'h1234, 5'd16);
    wait_words(1, ok);
    vec_cnt++;
    if (!ok || got_q[0] !== out_word_t'{data: 32'hABCD1234, bytes: 3'd4, last: 1'b0}) begin
      err_cnt++;
      $display("FAIL len_clamp_word: got %h want abcd1234/4/0", ok ? got_q[0] : out_word_t'('0));
    end
    vec_cnt++;
    if (len_err !== 1'b1) begin err_cnt++; $display("FAIL len_err_sticky: got %b want 1", len_err); end
    send_beat(16'h000F, 5'd4);
    send_beat(16'h0001, 5'd3);
    rst_n = 1'b0;
    #2;
    vec_cnt++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_bytes, bus.out_last, flush_done, len_err} !== '0) begin
      err_cnt++;
      $display("FAIL midreset_outputs: got rdy=%b vld=%b data=%h bytes=%0d last=%b fd=%b lerr=%b want all 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_bytes, bus.out_last, flush_done, len_err);
    end
`ifdef VLC_PACKER_STAT_EN
    vec_cnt++;
    if (bit_total !== 32'd0) begin err_cnt++; $display("FAIL midreset_bit_total: got %h want 0", bit_total); end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    got_q.delete();
    for (int i = 0; i < 8; i++) send_beat(16'h2, 5'd4);
    wait_words(1, ok);
    vec_cnt++;
    if (!ok || got_q[0] !== out_word_t'{data: 32'h22222222, bytes: 3'd4, last: 1'b0}) begin
      err_cnt++;
      $display("FAIL midreset_discard: got %h want 22222222/4/0", ok ? got_q[0] : out_word_t'('0));
    end
  endtask

  task automatic test_aligned_flush_drain();
    bit ok;
    got_q.delete(); fd_cnt = 0;
    bus.out_ready = 1'b0;
    send_beat(16'hABCD, 5'd16);
    send_beat(16'h00EF, 5'd8);
    pulse_flush();
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if ({bus.out_valid, bus.out_data, bus.out_bytes, bus.out_last} !== {1'b1, 32'hABCDEF80, 3'd4, 1'b1}) begin
      err_cnt++;
      $display("FAIL aligned_word: got vld=%b data=%h bytes=%0d last=%b want 1 abcdef80 4 1",
               bus.out_valid, bus.out_data, bus.out_bytes, bus.out_last);
    end
    pulse_flush();
    vec_cnt++;
    if (bus.in_ready !== 1'b0) begin err_cnt++; $display("FAIL drain_ready: got %b want 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    wait_flush_done(ok);
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL aligned_flush_done: flush_done got 0 want 1 within bound"); end
    repeat (10) @(posedge clk);
    #1;
    vec_cnt++;
    if ({got_q.size() == 1, fd_cnt == 1, bus.in_ready} !== 3'b111) begin
      err_cnt++;
      $display("FAIL aligned_no_extra: got words=%0d fd=%0d rdy=%b want 1 1 1", got_q.size(), fd_cnt, bus.in_ready);
    end
    got_q.delete();
    for (int i = 0; i < 8; i++) send_beat(16'h3, 5'd4);
    wait_words(1, ok);
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if (!ok || got_q[0] !== out_word_t'{data: 32'h33333333, bytes: 3'd4, last: 1'b0} || fd_cnt !== 1) begin
      err_cnt++;
      $display("FAIL after_flush_run: got w=%h fd=%0d want 33333333/4/0 fd=1",
               ok ? got_q[0] : out_word_t'('0), fd_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_word_pack();
    test_flush_partial();
    test_backpressure();
    test_exact_word_flush();
    test_len_err_and_reset();
    test_aligned_flush_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
